// File: rtl/johnson_counter_param_if.sv
// Control and status bundle for johnson_counter_param.
// The master drives the controls (en, dir, load, load_idx, div) and the slave drives the counter outputs.
interface johnson_counter_param_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4,
    parameter int IDX_W = $clog2(2*WIDTH)
) ();
    logic             en;
    logic             dir;
    logic             load;
    logic [IDX_W-1:0] load_idx;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] q;
    logic [IDX_W-1:0] idx;
    logic             step;
    logic             wrap;
    logic             illegal;

    modport master (
        output en, dir, load, load_idx, div,
        input  q, idx, step, wrap, illegal
    );

    modport slave (
        input  en, dir, load, load_idx, div,
        output q, idx, step, wrap, illegal
    );
endinterface

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter: prescaled up/down stepping, index load, phase decode, wrap pulse and illegal flag.
// Optional macro JOHNSON_SELFCORRECT_EN: an illegal code is forced back to zero on the next edge.
module johnson_counter_param #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input logic                    clk,
    input logic                    rst_n,
    johnson_counter_param_if.slave bus
);
    localparam int SEQ = 2*WIDTH;

    logic [WIDTH-1:0] q_q, q_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic [IDX_W-1:0] idx_c;
    logic             illegal_c;
    logic [WIDTH-1:0] fwd_c, rev_c;
    int               pc;

    // Phase k below WIDTH fills ones from the bottom; above it, zeros fill from the bottom.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        for (int i = 0; i < WIDTH; i++) begin
            c[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
        end
        return c;
    endfunction

    always_comb begin
        pc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + int'(q_q[i]);
        end
        idx_c     = q_q[WIDTH-1] ? IDX_W'(SEQ - pc) : IDX_W'(pc);
        // A code is legal exactly when re-encoding its decoded phase reproduces it.
        illegal_c = (code_of(int'(idx_c)) != q_q);
        fwd_c     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        rev_c     = {~q_q[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        q_d    = q_q;
        pre_d  = pre_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d   = (int'(bus.load_idx) >= SEQ) ? '0 : code_of(int'(bus.load_idx));
            pre_d = '0;
        end
`ifdef JOHNSON_SELFCORRECT_EN
        else if (illegal_c) begin
            q_d   = '0;
            pre_d = '0;
        end
`endif
        else if (bus.en) begin
            // >= lets a shrinking div fire on the very next enabled edge.
            if (pre_q >= bus.div) begin
                pre_d  = '0;
                step_d = 1'b1;
                if (bus.dir) begin
                    q_d    = rev_c;
                    wrap_d = (idx_c == '0);
                end else begin
                    q_d    = fwd_c;
                    wrap_d = (idx_c == IDX_W'(SEQ - 1));
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            pre_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            pre_q  <= pre_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.idx     = idx_c;
    assign bus.step    = step_q;
    assign bus.wrap    = wrap_q;
    assign bus.illegal = illegal_c;
endmodule
